// File: rtl/ctrl_cmd_readpixel.sv
// ctrl_cmd_readpixel: byte-serial "read pixel" payload decoder that feeds the framebuffer RAM write port.
// Define W128_EN for a two-byte little-endian column address (LSB then MSB); otherwise the column is one byte.
module ctrl_cmd_readpixel #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int PIXEL_HEIGHT    = 32,
  parameter int PIXEL_WIDTH     = 64,
  parameter int _UNUSED         = 0,
  localparam int RW = ($clog2(PIXEL_HEIGHT) > 1) ? $clog2(PIXEL_HEIGHT) : 1,
  localparam int CW = ($clog2(PIXEL_WIDTH) > 1) ? $clog2(PIXEL_WIDTH) : 1,
  localparam int PW = ($clog2(BYTES_PER_PIXEL) > 1) ? $clog2(BYTES_PER_PIXEL) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    data_in,
  output logic [RW-1:0] row,
  output logic [CW-1:0] column,
  output logic [PW-1:0] pixel,
  output logic [7:0]    data_out,
  output logic          ram_write_enable,
  output logic          ram_access_start,
  output logic          done
);

`ifdef W128_EN
  typedef enum logic [1:0] {S_ROW, S_COL_LSB, S_COL_MSB, S_DATA} state_t;
`else
  typedef enum logic [1:0] {S_ROW, S_COL_LSB, S_DATA} state_t;
`endif

  // Colour bytes are written most-significant first, so pixel counts down from LAST_K.
  localparam logic [PW-1:0] LAST_K = PW'(BYTES_PER_PIXEL - 1);

  state_t          state, state_nxt;
  logic [PW-1:0]   k, k_nxt;
  logic [RW-1:0]   row_nxt;
  logic [CW-1:0]   column_nxt;
  logic [PW-1:0]   pixel_nxt;
  logic [7:0]      data_nxt;
  logic            write_nxt;
  logic            toggle_nxt;
  logic            done_nxt;
`ifdef W128_EN
  logic [7:0]      lsb_byte, lsb_nxt;
`endif

  // _UNUSED is kept for interface compatibility; it has no function.
  if (_UNUSED != 0) begin : g_unused_param
  end

  always_comb begin
    // NOTE: every next-value gets its default first, so no branch can leave one unassigned and infer a latch.
    state_nxt  = state;
    k_nxt      = k;
    row_nxt    = row;
    column_nxt = column;
    pixel_nxt  = pixel;
    data_nxt   = '0;
    write_nxt  = 1'b0;
    toggle_nxt = ram_access_start;
    done_nxt   = 1'b0;
`ifdef W128_EN
    lsb_nxt    = lsb_byte;
`endif
    if (enable) begin
      case (state)
        S_ROW: begin
          row_nxt   = RW'(data_in);
          state_nxt = S_COL_LSB;
        end
        S_COL_LSB: begin
          column_nxt = CW'(data_in);
          k_nxt      = '0;
`ifdef W128_EN
          lsb_nxt    = data_in;
          state_nxt  = S_COL_MSB;
`else
          state_nxt  = S_DATA;
`endif
        end
`ifdef W128_EN
        S_COL_MSB: begin
          column_nxt = CW'({data_in, lsb_byte});
          state_nxt  = S_DATA;
        end
`endif
        S_DATA: begin
          write_nxt  = 1'b1;
          data_nxt   = data_in;
          pixel_nxt  = LAST_K - k;
          toggle_nxt = ~ram_access_start;
          if (k == LAST_K) begin
            done_nxt  = 1'b1;
            k_nxt     = '0;
            state_nxt = S_ROW;
          end else begin
            k_nxt = k + PW'(1);
          end
        end
        default: state_nxt = S_ROW;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_ROW;
      k                <= '0;
      row              <= '0;
      column           <= '0;
      pixel            <= '0;
      data_out         <= '0;
      ram_write_enable <= 1'b0;
      ram_access_start <= 1'b0;
      done             <= 1'b0;
`ifdef W128_EN
      lsb_byte         <= '0;
`endif
    end else begin
      state            <= state_nxt;
      k                <= k_nxt;
      row              <= row_nxt;
      column           <= column_nxt;
      pixel            <= pixel_nxt;
      data_out         <= data_nxt;
      ram_write_enable <= write_nxt;
      ram_access_start <= toggle_nxt;
      done             <= done_nxt;
`ifdef W128_EN
      lsb_byte         <= lsb_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ctrl_cmd_readpixel.sv
// Directed bench for ctrl_cmd_readpixel: inputs driven and outputs sampled on the falling clock edge.
// Built with W128_EN it runs the reset and two-byte column scenarios against a 512-column panel.
module tb_ctrl_cmd_readpixel;

`ifdef W128_EN
  localparam int TB_WIDTH = 512;
  localparam int TB_CW    = 9;
`else
  localparam int TB_WIDTH = 64;
  localparam int TB_CW    = 6;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [7:0]       data_in = 8'h00;
  logic [4:0]       row;
  logic [TB_CW-1:0] column;
  logic [0:0]       pixel;
  logic [7:0]       data_out;
  logic             ram_write_enable;
  logic             ram_access_start;
  logic             done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic exp_ras = 1'b0;

  ctrl_cmd_readpixel #(
    .BYTES_PER_PIXEL(2),
    .PIXEL_HEIGHT(32),
    .PIXEL_WIDTH(TB_WIDTH),
    ._UNUSED(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .data_in(data_in),
    .row(row),
    .column(column),
    .pixel(pixel),
    .data_out(data_out),
    .ram_write_enable(ram_write_enable),
    .ram_access_start(ram_access_start),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Called at a falling edge: strobe one byte, return at the next falling edge (cycle after the strobe).
  task automatic drive_byte(input logic [7:0] b);
    enable  = 1'b1;
    data_in = b;
    @(negedge clk);
    enable  = 1'b0;
    data_in = 8'h00;
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] r, input logic [7:0] c,
                         input logic [7:0] d0, input logic [7:0] d1, input int gap,
                         input logic [4:0] exp_row, input logic [TB_CW-1:0] exp_col);
    drive_byte(r);
    tests++;
    if ({row, ram_write_enable, data_out, done} !== {exp_row, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL %s_row: row=%0d we=%b dout=%h done=%b, expected row=%0d we=0 dout=00 done=0",
               tag, row, ram_write_enable, data_out, done, exp_row);
    end
    repeat (gap) @(negedge clk);
    drive_byte(c);
    tests++;
    if ({column, row, ram_write_enable, done} !== {exp_col, exp_row, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL %s_col: column=%0d row=%0d we=%b done=%b, expected column=%0d row=%0d we=0 done=0",
               tag, column, row, ram_write_enable, done, exp_col, exp_row);
    end
    repeat (gap) @(negedge clk);
    drive_byte(d0);
    exp_ras = ~exp_ras;
    tests++;
    if ({ram_write_enable, data_out, pixel, done, ram_access_start} !== {1'b1, d0, 1'b1, 1'b0, exp_ras}) begin
      fails++;
      $display("FAIL %s_data0: we=%b dout=%h pixel=%0d done=%b ras=%b, expected we=1 dout=%h pixel=1 done=0 ras=%b",
               tag, ram_write_enable, data_out, pixel, done, ram_access_start, d0, exp_ras);
    end
    if (gap > 0) begin
      @(negedge clk);
      tests++;
      if ({ram_write_enable, data_out, pixel, done, ram_access_start} !== {1'b0, 8'h00, 1'b1, 1'b0, exp_ras}) begin
        fails++;
        $display("FAIL %s_idle: we=%b dout=%h pixel=%0d done=%b ras=%b, expected we=0 dout=00 pixel=1 done=0 ras=%b",
                 tag, ram_write_enable, data_out, pixel, done, ram_access_start, exp_ras);
      end
      repeat (gap - 1) @(negedge clk);
    end
    drive_byte(d1);
    exp_ras = ~exp_ras;
    tests++;
    if ({ram_write_enable, data_out, pixel, done, ram_access_start} !== {1'b1, d1, 1'b0, 1'b1, exp_ras}) begin
      fails++;
      $display("FAIL %s_data1: we=%b dout=%h pixel=%0d done=%b ras=%b, expected we=1 dout=%h pixel=0 done=1 ras=%b",
               tag, ram_write_enable, data_out, pixel, done, ram_access_start, d1, exp_ras);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    tests++;
    if ({ram_write_enable, data_out, pixel, done, ram_access_start} !== {1'b0, 8'h00, 1'b0, 1'b0, exp_ras}) begin
      fails++;
      $display("FAIL %s_idle: we=%b dout=%h pixel=%0d done=%b ras=%b, expected we=0 dout=00 pixel=0 done=0 ras=%b",
               tag, ram_write_enable, data_out, pixel, done, ram_access_start, exp_ras);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    enable = 1'b1;
    data_in = 8'h5A;
    repeat (3) @(negedge clk);
    tests++;
    if ({row, column, pixel, data_out, ram_write_enable, ram_access_start, done} !== '0) begin
      fails++;
      $display("FAIL reset_values: row=%0d col=%0d pixel=%0d dout=%h we=%b ras=%b done=%b, expected all 0",
               row, column, pixel, data_out, ram_write_enable, ram_access_start, done);
    end
    enable = 1'b0;
    data_in = 8'h00;
    reset = 1'b1;
    exp_ras = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    run_cmd("basic", 8'h05, 8'h0A, 8'hAB, 8'hCD, 15, 5'd5, TB_CW'(10));
    check_idle("basic_end");
  endtask

  task automatic test_back_to_back;
    int start_cnt;
    start_cnt = done_cnt;
    run_cmd("b2b_first", 8'h05, 8'h0A, 8'hAB, 8'hCD, 0, 5'd5, TB_CW'(10));
    run_cmd("b2b_second", 8'h05, 8'h0A, 8'hAB, 8'hCD, 0, 5'd5, TB_CW'(10));
    check_idle("b2b_end");
    tests++;
    if (done_cnt - start_cnt !== 2) begin
      fails++;
      $display("FAIL b2b_done_count: got %0d done pulses, expected 2", done_cnt - start_cnt);
    end
  endtask

  task automatic test_truncate;
    run_cmd("trunc", 8'hE5, 8'hFF, 8'h12, 8'h34, 2, 5'd5, TB_CW'(63));
    check_idle("trunc_end");
  endtask

  task automatic test_consecutive;
    run_cmd("consec", 8'h07, 8'h14, 8'h5A, 8'hA5, 0, 5'd7, TB_CW'(20));
    check_idle("consec_end");
  endtask

  task automatic test_mid_reset;
    int start_cnt;
    drive_byte(8'h03);
    drive_byte(8'h04);
    drive_byte(8'h11);
    exp_ras = ~exp_ras;
    tests++;
    if ({row, column, ram_write_enable, data_out, pixel, done} !== {5'd3, TB_CW'(4), 1'b1, 8'h11, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL midrst_partial: row=%0d col=%0d we=%b dout=%h pixel=%0d done=%b, expected 3 4 1 11 1 0",
               row, column, ram_write_enable, data_out, pixel, done);
    end
    reset = 1'b0;
    enable = 1'b1;
    data_in = 8'h22;
    @(negedge clk);
    tests++;
    if ({row, column, pixel, data_out, ram_write_enable, ram_access_start, done} !== '0) begin
      fails++;
      $display("FAIL midrst_in_reset: row=%0d col=%0d pixel=%0d dout=%h we=%b ras=%b done=%b, expected all 0",
               row, column, pixel, data_out, ram_write_enable, ram_access_start, done);
    end
    @(negedge clk);
    enable = 1'b0;
    data_in = 8'h00;
    reset = 1'b1;
    exp_ras = 1'b0;
    @(negedge clk);
    start_cnt = done_cnt;
    run_cmd("midrst_after", 8'h05, 8'h0A, 8'hAB, 8'hCD, 2, 5'd5, TB_CW'(10));
    check_idle("midrst_end");
    tests++;
    if (done_cnt - start_cnt !== 1) begin
      fails++;
      $display("FAIL midrst_done_count: got %0d done pulses, expected 1", done_cnt - start_cnt);
    end
  endtask

`ifdef W128_EN
  task automatic test_w128;
    drive_byte(8'h02);
    drive_byte(8'h34);
    tests++;
    if ({row, column} !== {5'd2, TB_CW'(9'h034)}) begin
      fails++;
      $display("FAIL w128_lsb: row=%0d col=%h, expected row=2 col=034", row, column);
    end
    drive_byte(8'h01);
    tests++;
    if ({column, ram_write_enable} !== {TB_CW'(9'h134), 1'b0}) begin
      fails++;
      $display("FAIL w128_msb: col=%h we=%b, expected col=134 we=0", column, ram_write_enable);
    end
    drive_byte(8'h10);
    exp_ras = ~exp_ras;
    tests++;
    if ({ram_write_enable, data_out, pixel, done, ram_access_start} !== {1'b1, 8'h10, 1'b1, 1'b0, exp_ras}) begin
      fails++;
      $display("FAIL w128_data0: we=%b dout=%h pixel=%0d done=%b ras=%b, expected 1 10 1 0 %b",
               ram_write_enable, data_out, pixel, done, ram_access_start, exp_ras);
    end
    drive_byte(8'h20);
    exp_ras = ~exp_ras;
    tests++;
    if ({ram_write_enable, data_out, pixel, done, ram_access_start} !== {1'b1, 8'h20, 1'b0, 1'b1, exp_ras}) begin
      fails++;
      $display("FAIL w128_data1: we=%b dout=%h pixel=%0d done=%b ras=%b, expected 1 20 0 1 %b",
               ram_write_enable, data_out, pixel, done, ram_access_start, exp_ras);
    end
    check_idle("w128_end");
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
`ifdef W128_EN
    test_w128();
`else
    test_basic();
    test_back_to_back();
    test_truncate();
    test_mid_reset();
    test_consecutive();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
